// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiply consumes MUL_BITS of operand2 per cycle. Divide is radix-2 restoring.
// Each op ends with one finish cycle that applies the sign fix-up and selects the result.
// Optional feature macro: MUL_DIV_EARLY_OUT_EN. When it is defined, a zero operand skips
// the iterations and goes straight to the finish cycle.
module mul_div_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 8,
  parameter int TAG_W    = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_kill,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [2:0]         i_in_op,
  input  logic [WIDTH-1:0]   i_in_a,
  input  logic [WIDTH-1:0]   i_in_b,
  input  logic [TAG_W-1:0]   i_in_tag,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_out_result,
  output logic [TAG_W-1:0]   o_out_tag
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / MUL_BITS);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);
`ifdef MUL_DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [2:0]            r_op;
  logic [TAG_W-1:0]      r_tag;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;
  logic                  r_sign_a;
  logic                  r_sign_b;
  logic                  r_zero;
  logic [2*WIDTH-1:0]    r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_result;

  // Operand conditioning at accept time
  logic                  w_accept;
  logic                  w_a_signed;
  logic                  w_b_signed;
  logic                  w_sign_a;
  logic                  w_sign_b;
  logic [WIDTH-1:0]      w_abs_a;
  logic [WIDTH-1:0]      w_abs_b;
  logic                  w_zero_in;

  assign o_in_ready = (r_state == S_IDLE) & ~i_kill & ~i_reset;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_a_signed = (i_in_op == 3'b001) | (i_in_op == 3'b010) |
                      (i_in_op == 3'b100) | (i_in_op == 3'b110);
  assign w_b_signed = (i_in_op == 3'b001) | (i_in_op == 3'b100) | (i_in_op == 3'b110);
  assign w_sign_a   = w_a_signed & i_in_a[WIDTH-1];
  assign w_sign_b   = w_b_signed & i_in_b[WIDTH-1];
  assign w_abs_a    = w_sign_a ? -i_in_a : i_in_a;
  assign w_abs_b    = w_sign_b ? -i_in_b : i_in_b;
  assign w_zero_in  = i_in_op[2] ? (i_in_b == '0) : ((i_in_a == '0) | (i_in_b == '0));

  // Multiply step: |a| times the lowest remaining slice of |b|, aligned to its weight
  logic [WIDTH+MUL_BITS-1:0] w_pp;
  logic [2*WIDTH-1:0]        w_pp_sh;
  assign w_pp    = {{MUL_BITS{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b[MUL_BITS-1:0]};
  assign w_pp_sh = {{(WIDTH-MUL_BITS){1'b0}}, w_pp} << (r_cnt * MUL_BITS);

  // Divide step: acc high half is the partial remainder, low half shifts dividend out / quotient in
  logic [WIDTH:0]        w_rem_sh;
  logic [WIDTH:0]        w_diff;
  logic                  w_ge;
  logic [WIDTH-1:0]      w_rem_new;
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_new = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  // Finish cycle: sign fix-up and result select
  logic                  w_last;
  logic                  w_early;
  logic                  w_neg;
  logic [2*WIDTH-1:0]    w_prod;
  logic [WIDTH-1:0]      w_q_raw;
  logic [WIDTH-1:0]      w_r_raw;
  logic [WIDTH-1:0]      w_quo;
  logic [WIDTH-1:0]      w_rem;
  logic [WIDTH-1:0]      w_sel;
  assign w_last  = (r_cnt == ((r_state == S_DIV) ? DIV_LAST : MUL_LAST));
  assign w_early = EARLY_OUT & r_zero & (r_cnt == '0);
  assign w_neg   = r_sign_a ^ r_sign_b;
  assign w_prod  = w_neg ? -r_acc : r_acc;
  assign w_q_raw = r_acc[WIDTH-1:0];
  assign w_r_raw = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo   = (w_neg && (r_b != '0)) ? -w_q_raw : w_q_raw;
  assign w_rem   = r_sign_a ? -w_r_raw : w_r_raw;

  // Pick the result word for the latched op
  always_comb begin
    w_sel = '0;
    case (r_op)
      3'b000:                 w_sel = w_prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_sel = w_prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_sel = w_quo;
      default:                w_sel = w_rem;
    endcase
  end

  // Next-state logic; kill forces IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:        if (w_accept) w_state_next = i_in_op[2] ? S_DIV : S_MUL;
      S_MUL, S_DIV:  if (w_last) w_state_next = S_DONE;
      S_DONE:        if (i_out_ready) w_state_next = S_IDLE;
      default:       w_state_next = S_IDLE;
    endcase
    if (i_kill) w_state_next = S_IDLE;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Datapath: latch operands, iterate, capture the final result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_op     <= '0;
      r_tag    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_zero   <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (!i_kill) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= i_in_op;
            r_tag    <= i_in_tag;
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_zero   <= w_zero_in;
            r_cnt    <= '0;
            r_acc    <= i_in_op[2] ? {{WIDTH{1'b0}}, w_abs_a} : '0;
          end
        end
        S_MUL: begin
          if (w_last) begin
            r_result <= w_sel;
          end else if (w_early) begin
            r_acc <= '0;
            r_cnt <= MUL_LAST;
          end else begin
            r_acc <= r_acc + w_pp_sh;
            r_b   <= r_b >> MUL_BITS;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DIV: begin
          if (w_last) begin
            r_result <= w_sel;
          end else if (w_early) begin
            // Divide by zero: remainder |a|, quotient all ones
            r_acc <= {r_a, {WIDTH{1'b1}}};
            r_cnt <= DIV_LAST;
          end else begin
            r_acc <= {w_rem_new, r_acc[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid  = (r_state == S_DONE);
  assign o_out_result = r_result;
  assign o_out_tag    = r_tag;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH=32, MUL_BITS=8, TAG_W=5).
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset, kill, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  tag, out_tag;

`ifdef MUL_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_div_unit #(.WIDTH(32), .MUL_BITS(8), .TAG_W(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_kill(kill),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_op(op),
    .i_in_a(a), .i_in_b(b), .i_in_tag(tag),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_result(result), .o_out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int max_cycles, output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    while (!got && lat < max_cycles) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) got = 1'b1;
    end
  endtask

  // Issue one op and check result, tag, latency and the return to IDLE
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [4:0] t,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    op = o; a = aa; b = bb; tag = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(60, lat, got);
    chk({name, " valid"}, 32'(got), 32'd1);
    if (got) begin
      chk({name, " result"}, result, exp);
      chk({name, " tag"}, 32'(out_tag), 32'(t));
      chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    end
    $display("op=%0d a=%08h b=%08h tag=%0d -> result=%08h tag=%0d latency=%0d",
             o, aa, bb, t, result, out_tag, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " idle valid"}, 32'(out_valid), 32'd0);
    chk({name, " idle ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic no_valid_for(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk({name, " no result"}, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          zero;
  } vec_t;

  vec_t vecs[20];
  int   nv = 0;

  task automatic add(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                     input logic [31:0] e, input bit z);
    vecs[nv].op = o; vecs[nv].a = aa; vecs[nv].b = bb; vecs[nv].exp = e; vecs[nv].zero = z;
    nv++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit got;
    int el;

    reset = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0; tag = '0;

    //        op      a             b             expected      zero
    add(3'b000, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0); // MUL
    add(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0); // MULH
    add(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); // MULHU
    add(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); // MULHSU
    add(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0); // DIV -7/2
    add(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0); // REM -7%2
    add(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0); // DIV overflow
    add(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0); // REM overflow
    add(3'b101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1); // DIVU by 0
    add(3'b110, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 1'b1); // REM by 0
    add(3'b100, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1); // DIV by 0
    add(3'b000, 32'h0000_0000, 32'h0000_3039, 32'h0000_0000, 1'b1); // MUL a=0
    add(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0); // MULH min*min
    add(3'b101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0); // DIVU 100/7
    add(3'b111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0); // REMU 100%7
    add(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 1'b0); // MUL -3*5
    add(3'b010, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0); // MULHSU -2*3
    add(3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0); // DIV 7/-2
    add(3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0); // REM 7%-2
    add(3'b011, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 1'b0); // MULHU

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", result, 32'd0);
    chk("reset out_tag", 32'(out_tag), 32'd0);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    // Vector table
    for (int i = 0; i < nv; i++) begin
      el = (EARLY && vecs[i].zero) ? 2 : (vecs[i].op[2] ? 33 : 5);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
             vecs[i].exp, el);
    end

    // Backpressure: result and tag hold while out_ready is low
    @(negedge clk);
    op = 3'b000; a = 32'd3; b = 32'd5; tag = 5'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(10, lat, got);
    chk("bp valid", 32'(got), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp hold result", result, 32'd15);
      chk("bp hold tag", 32'(out_tag), 32'd3);
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
    end
    $display("backpressure: result=%08h tag=%0d held 10 cycles", result, out_tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    chk("bp release valid", 32'(out_valid), 32'd0);

    // Kill at DIV iteration 10
    @(negedge clk);
    op = 3'b101; a = 32'd100; b = 32'd7; tag = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    #1;
    chk("kill in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    #1;
    chk("kill valid", 32'(out_valid), 32'd0);
    chk("kill in_ready after", 32'(in_ready), 32'd1);
    no_valid_for("kill div", 40);
    $display("kill during DIV: no result returned");
    run_op("after kill", 3'b011, 32'd3, 32'd5, 5'd7, 32'd0, 5);

    // Reset at MUL iteration 2
    @(negedge clk);
    op = 3'b000; a = 32'h0001_0003; b = 32'd5; tag = 5'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid reset in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mid reset valid", 32'(out_valid), 32'd0);
    chk("mid reset result", result, 32'd0);
    chk("mid reset tag", 32'(out_tag), 32'd0);
    chk("mid reset in_ready after", 32'(in_ready), 32'd1);
    no_valid_for("reset mul", 10);
    $display("reset during MUL: no result returned");
    run_op("after reset", 3'b011, 32'd3, 32'd5, 5'd7, 32'd0, 5);

    // Kill in DONE together with out_ready drops the result
    @(negedge clk);
    op = 3'b000; a = 32'd6; b = 32'd7; tag = 5'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(10, lat, got);
    chk("done kill valid", 32'(got), 32'd1);
    chk("done kill result", result, 32'd42);
    kill = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; out_ready = 1'b0;
    #1;
    chk("done kill dropped", 32'(out_valid), 32'd0);
    chk("done kill in_ready", 32'(in_ready), 32'd1);
    no_valid_for("done kill", 10);
    $display("kill in DONE: result dropped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
